// File: rtl/board_store.sv
// Double-buffered Life generation store for the VGA cell renderer.
// Optional `freeze` input enabled by defining BOARD_STORE_FREEZE_EN.
module board_store #(
  parameter logic [63:0] INIT_PATTERN = 64'h0000_0000_0000_0E00,
  parameter int          GEN_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  input  logic [63:0]      upd_data,
  output logic             upd_ready,
  input  logic             frame_end,
  input  logic [1:0]       array_pos,
  output logic [15:0]      alive,
  output logic [15:0]      alive_prev,
  output logic [63:0]      cur_board,
  output logic [GEN_W-1:0] gen_count,
  output logic             pending
`ifdef BOARD_STORE_FREEZE_EN
  ,
  input  logic             freeze
`endif
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t             state_q, state_d;
  logic [63:0]        cur_q, cur_d;
  logic [63:0]        prev_q, prev_d;
  logic [63:0]        staged_q, staged_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               hold;

`ifdef BOARD_STORE_FREEZE_EN
  assign hold = freeze;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= INIT_PATTERN;
      prev_q   <= '0;
      staged_q <= '0;
      gen_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      prev_q   <= prev_d;
      staged_q <= staged_d;
      gen_q    <= gen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    staged_d  = staged_q;
    gen_d     = gen_q;
    upd_ready = 1'b0;
    pending   = 1'b0;
    case (state_q)
      IDLE: begin
        // A frame_end arriving with the handshake only stages; commit waits for the next one.
        upd_ready = 1'b1;
        if (upd_valid) begin
          staged_d = upd_data;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        pending = 1'b1;
        if (frame_end && !hold) begin
          prev_d  = cur_q;
          cur_d   = staged_q;
          gen_d   = gen_q + GEN_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alive      = cur_q[{array_pos, 4'b0000} +: 16];
  assign alive_prev = prev_q[{array_pos, 4'b0000} +: 16];
  assign cur_board  = cur_q;
  assign gen_count  = gen_q;

endmodule

// File: tb/tb_board_store.sv
// Scoreboard bench for board_store: staged words queued on accept, checked at commit.
module tb_board_store;

  localparam logic [63:0] INIT = 64'h0000_0000_0000_0E00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic [63:0] upd_data;
  logic        upd_ready;
  logic        frame_end;
  logic [1:0]  array_pos;
  logic [15:0] alive, alive_prev;
  logic [63:0] cur_board;
  logic [15:0] gen_count;
  logic        pending;
  logic        freeze;
  logic        upd_ready2, pending2;
  logic [15:0] alive2, alive_prev2;
  logic [63:0] cur_board2;
  logic [2:0]  gen_count2;

  always #10 clk = ~clk;

  board_store u_dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_data(upd_data),
    .upd_ready(upd_ready), .frame_end(frame_end), .array_pos(array_pos),
    .alive(alive), .alive_prev(alive_prev), .cur_board(cur_board),
    .gen_count(gen_count), .pending(pending)
`ifdef BOARD_STORE_FREEZE_EN
    , .freeze(freeze)
`endif
  );

  // Narrow counter instance so generation wrap is reached in a short run.
  board_store #(.GEN_W(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_data(upd_data),
    .upd_ready(upd_ready2), .frame_end(frame_end), .array_pos(array_pos),
    .alive(alive2), .alive_prev(alive_prev2), .cur_board(cur_board2),
    .gen_count(gen_count2), .pending(pending2)
`ifdef BOARD_STORE_FREEZE_EN
    , .freeze(freeze)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_cur, m_prev, m_staged;
  int          m_gen;
  logic        m_pend;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; the model and scoreboard evolve from the inputs driven this cycle.
  task automatic tick();
    logic commit;
    logic [63:0] want;
    commit = 1'b0;
    if (!rst_n) begin
      m_cur = INIT; m_prev = '0; m_staged = '0; m_gen = 0; m_pend = 1'b0;
      sb_q.delete();
    end else if (!m_pend) begin
      if (upd_valid) begin
        m_staged = upd_data;
        m_pend   = 1'b1;
        sb_q.push_back(upd_data);
      end
    end else if (frame_end && !freeze) begin
      m_prev = m_cur;
      m_cur  = m_staged;
      m_gen  = (m_gen + 1) % 65536;
      m_pend = 1'b0;
      commit = 1'b1;
    end
    @(posedge clk);
    #1;
    if (commit) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        want = sb_q.pop_front();
        chk("sb_commit", cur_board, want);
      end
    end
  endtask

  task automatic check_all();
    chk("upd_ready", {63'd0, upd_ready}, {63'd0, ~m_pend});
    chk("pending", {63'd0, pending}, {63'd0, m_pend});
    chk("cur_board", cur_board, m_cur);
    chk("gen_count", {48'd0, gen_count}, 64'(m_gen));
    chk("gen_wrap", {61'd0, gen_count2}, 64'(m_gen % 8));
    for (int p = 0; p < 4; p++) begin
      array_pos = 2'(p);
      #1;
      chk("alive", {48'd0, alive}, {48'd0, m_cur[16*p +: 16]});
      chk("alive_prev", {48'd0, alive_prev}, {48'd0, m_prev[16*p +: 16]});
    end
  endtask

  initial begin
    logic [63:0] wa, wb;
    rst_n = 1'b0; upd_valid = 1'b0; upd_data = '0; frame_end = 1'b0;
    array_pos = 2'd0; freeze = 1'b0;
    m_cur = '0; m_prev = '0; m_staged = '0; m_gen = 0; m_pend = 1'b0;

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    array_pos = 2'd0; #1;
    chk("rst_alive", {48'd0, alive}, 64'h0E00);
    chk("rst_alive_prev", {48'd0, alive_prev}, 64'h0);
    chk("rst_ready", {63'd0, upd_ready}, 64'd1);
    chk("rst_gen", {48'd0, gen_count}, 64'd0);
    chk("rst_pending", {63'd0, pending}, 64'd0);

    // Basic accept and commit
    upd_valid = 1'b1; upd_data = 64'hFFFF_0000_0000_1234;
    tick();
    upd_valid = 1'b0;
    chk("acc_pending", {63'd0, pending}, 64'd1);
    chk("acc_ready", {63'd0, upd_ready}, 64'd0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    array_pos = 2'd0; #1;
    chk("c1_alive0", {48'd0, alive}, 64'h1234);
    chk("c1_prev0", {48'd0, alive_prev}, 64'h0E00);
    array_pos = 2'd3; #1;
    chk("c1_alive3", {48'd0, alive}, 64'hFFFF);
    chk("c1_gen", {48'd0, gen_count}, 64'd1);
    chk("c1_ready", {63'd0, upd_ready}, 64'd1);
    check_all();

    // Stall: second word held with valid high across 100 cycles without frame_end
    wa = 64'hA5A5_0F0F_1111_2222; wb = 64'h5A5A_F0F0_3333_4444;
    upd_valid = 1'b1; upd_data = wa;
    tick();
    upd_data = wb;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("stall_ready", {63'd0, upd_ready}, 64'd0);
      chk("stall_cur", cur_board, 64'hFFFF_0000_0000_1234);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("stall_commit_a", cur_board, wa);
    check_all();
    tick();
    upd_valid = 1'b0;
    check_all();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("stall_commit_b", cur_board, wb);
    check_all();

    // Handshake coincident with frame_end in IDLE stages only
    upd_valid = 1'b1; frame_end = 1'b1; upd_data = 64'h0123_4567_89AB_CDEF;
    tick();
    upd_valid = 1'b0; frame_end = 1'b0;
    chk("coinc_gen", {48'd0, gen_count}, 64'd3);
    check_all();
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("coinc_commit_gen", {48'd0, gen_count}, 64'd4);
    check_all();

    // frame_end in IDLE alone does nothing
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_all();

    // Reset while PENDING drops the staged board
    upd_valid = 1'b1; upd_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    upd_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("rstp_cur", cur_board, INIT);
    chk("rstp_gen", {48'd0, gen_count}, 64'd0);
    chk("rstp_pending", {63'd0, pending}, 64'd0);
    check_all();

`ifdef BOARD_STORE_FREEZE_EN
    // Freeze blocks commits until released
    upd_valid = 1'b1; upd_data = 64'h1111_2222_3333_4444;
    tick();
    upd_valid = 1'b0; freeze = 1'b1;
    for (int k = 0; k < 2; k++) begin
      frame_end = 1'b1; tick();
      frame_end = 1'b0; tick();
      chk("frz_gen", {48'd0, gen_count}, 64'd0);
      chk("frz_pending", {63'd0, pending}, 64'd1);
    end
    freeze = 1'b0; frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("frz_commit_gen", {48'd0, gen_count}, 64'd1);
    chk("frz_commit_cur", cur_board, 64'h1111_2222_3333_4444);
    check_all();
`endif

    // Random traffic; also drives the narrow counter through several wraps
    for (int i = 0; i < 400; i++) begin
      upd_valid = 1'($urandom_range(0, 1));
      upd_data  = {$urandom, $urandom};
      frame_end = ($urandom_range(0, 2) == 0);
`ifdef BOARD_STORE_FREEZE_EN
      freeze    = ($urandom_range(0, 3) == 0);
`endif
      tick();
      check_all();
    end
    upd_valid = 1'b0; frame_end = 1'b0; freeze = 1'b0;
    chk("wrap_reached", 64'(m_gen >= 8), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
